// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file: default geometry
// and the controller state encoding.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard. A reservation sets a bit, either write port
// clears it, and the post-reset walk clears one bit per cycle. Register 0 is
// never busy. Two combinational lookups serve the read ports.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              init_clr_i,
  input  logic [ADDR_W-1:0] init_idx_i,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr1_en_i,
  input  logic [ADDR_W-1:0] clr1_addr_i,
  input  logic              clr2_en_i,
  input  logic [ADDR_W-1:0] clr2_addr_i,
  input  logic [ADDR_W-1:0] look1_addr_i,
  input  logic [ADDR_W-1:0] look2_addr_i,
  output logic              busy1_o,
  output logic              busy2_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: clears first so a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (init_clr_i) begin
      busy_d[init_idx_i] = 1'b0;
    end else begin
      if (clr1_en_i) busy_d[clr1_addr_i] = 1'b0;
      if (clr2_en_i) busy_d[clr2_addr_i] = 1'b0;
      if (set_en_i)  busy_d[set_addr_i]  = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register; its contents are cleared by the init walk.
  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  assign busy1_o = busy_q[look1_addr_i];
  assign busy2_o = busy_q[look2_addr_i];

endmodule

// File: rtl/multiport_reg_file.sv
// Dual-write, dual-read register file with hardwired zero register,
// sequential post-reset clear, and busy scoreboard.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data
// to the read ports.
module multiport_reg_file
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2,
  output logic              busy1,
  output logic              busy2,
  input  logic              WE,
  input  logic              WE2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] write_addr2,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] data2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic run;
  logic init_clr;
  logic wr1_en, wr2_en, rsv_ok;
  logic sb_busy1, sb_busy2;

  // Gated enables: nothing lands while reset is asserted, and register 0
  // silently drops writes and reservations.
  assign run      = (state_q == RUN);
  assign init_clr = !rst && !run;
  assign wr1_en   = !rst && run && WE  && (write_addr  != '0);
  assign wr2_en   = !rst && run && WE2 && (write_addr2 != '0);
  assign rsv_ok   = !rst && run && rsv_en && (rsv_addr != '0);
  assign ready    = run;

  // Controller state and clear-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Init walk advances one register per cycle and hands over to RUN on
  // the edge that clears the last register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Register array: init walk clears, otherwise port 2 is applied after
  // port 1 so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (init_clr) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wr1_en) mem_q[write_addr]  <= data;
      if (wr2_en) mem_q[write_addr2] <= data2;
    end
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .init_clr_i  (init_clr),
    .init_idx_i  (cnt_q),
    .set_en_i    (rsv_ok),
    .set_addr_i  (rsv_addr),
    .clr1_en_i   (wr1_en),
    .clr1_addr_i (write_addr),
    .clr2_en_i   (wr2_en),
    .clr2_addr_i (write_addr2),
    .look1_addr_i(read_addr1),
    .look2_addr_i(read_addr2),
    .busy1_o     (sb_busy1),
    .busy2_o     (sb_busy2)
  );

  // Read port data: zero outside RUN and for register 0, optional forward.
  function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] stored);
    logic [DATA_W-1:0] v;
    v = stored;
`ifdef RF_BYPASS_EN
    if (wr2_en && (write_addr2 == a))     v = data2;
    else if (wr1_en && (write_addr == a)) v = data;
`endif
    if (!run || (a == '0)) v = '0;
    return v;
  endfunction

  // Busy lookup: a forwarded register is not busy unless it is being
  // reserved in the same cycle.
  function automatic logic bz_sel(input logic [ADDR_W-1:0] a, input logic sb);
    logic b;
    b = sb;
`ifdef RF_BYPASS_EN
    if ((wr2_en && (write_addr2 == a)) || (wr1_en && (write_addr == a)))
      b = rsv_ok && (rsv_addr == a);
`endif
    if (!run || (a == '0)) b = 1'b0;
    return b;
  endfunction

  // Combinational read and busy outputs for both ports.
  always_comb begin
    read1 = rd_sel(read_addr1, mem_q[read_addr1]);
    read2 = rd_sel(read_addr2, mem_q[read_addr2]);
    busy1 = bz_sel(read_addr1, sb_busy1);
    busy2 = bz_sel(read_addr2, sb_busy2);
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Self-checking bench for multiport_reg_file: reset/init sequence, a table
// of directed write/reserve vectors, randomized traffic against an
// array-based reference model, and a mid-run reset.
module tb_multiport_reg_file;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] read_addr1, read_addr2;
  logic [DW-1:0] read1, read2;
  logic          busy1, busy2;
  logic          WE, WE2;
  logic [AW-1:0] write_addr, write_addr2;
  logic [DW-1:0] data, data2;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          ready;

  int errors = 0;
  int checks = 0;

  multiport_reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read1(read1), .read2(read2), .busy1(busy1), .busy2(busy2),
    .WE(WE), .WE2(WE2), .write_addr(write_addr), .write_addr2(write_addr2),
    .data(data), .data2(data2), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ready(ready)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, busy flags, cycles left in init.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy[DEPTH];
  int            m_init_left = DEPTH;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    WE = 0; WE2 = 0; rsv_en = 0;
    write_addr = '0; write_addr2 = '0; rsv_addr = '0;
    data = '0; data2 = '0;
  endtask

  // One clock edge; the model advances using the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_init_left = DEPTH;
    end else if (m_init_left > 0) begin
      m_init_left--;
      if (m_init_left == 0)
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    end else begin
      if (WE  && write_addr  != 0) begin m_mem[write_addr]  = data;  m_busy[write_addr]  = 0; end
      if (WE2 && write_addr2 != 0) begin m_mem[write_addr2] = data2; m_busy[write_addr2] = 0; end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
    end
    #1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (m_init_left != 0 || a == 0) return '0;
    v = m_mem[a];
`ifdef RF_BYPASS_EN
    if (!rst) begin
      if (WE2 && write_addr2 == a)     v = data2;
      else if (WE && write_addr == a)  v = data;
    end
`endif
    return v;
  endfunction

  function automatic logic exp_bz(input logic [AW-1:0] a);
    logic b;
    if (m_init_left != 0 || a == 0) return 1'b0;
    b = m_busy[a];
`ifdef RF_BYPASS_EN
    if (!rst && ((WE2 && write_addr2 == a) || (WE && write_addr == a)))
      b = rsv_en && (rsv_addr == a);
`endif
    return b;
  endfunction

  task automatic check_all(input string nm);
    chk({nm, "_read1"}, read1, exp_rd(read_addr1));
    chk({nm, "_read2"}, read2, exp_rd(read_addr2));
    chk({nm, "_busy1"}, 32'(busy1), 32'(exp_bz(read_addr1)));
    chk({nm, "_busy2"}, 32'(busy2), 32'(exp_bz(read_addr2)));
    chk({nm, "_ready"}, 32'(ready), 32'(m_init_left == 0));
  endtask

  typedef struct {
    string         name;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    logic          we2;
    logic [AW-1:0] wa2;
    logic [DW-1:0] d2;
    logic          rsv;
    logic [AW-1:0] ra;
    logic [AW-1:0] chk_a;
    logic [DW-1:0] exp_d;
    logic          exp_b;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"wr3",      1, 5'd3, 32'h3,        0, 5'd0,  32'h0,    0, 5'd0, 5'd3,  32'h3,    0};
    vecs[1] = '{"collide5", 1, 5'd5, 32'hAAAA,     1, 5'd5,  32'h5555, 0, 5'd0, 5'd5,  32'h5555, 0};
    vecs[2] = '{"zero_reg", 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0,  32'h0,    1, 5'd0, 5'd0,  32'h0,    0};
    vecs[3] = '{"rsv7",     0, 5'd0, 32'h0,        0, 5'd0,  32'h0,    1, 5'd7, 5'd7,  32'h0,    1};
    vecs[4] = '{"clr7",     0, 5'd0, 32'h0,        1, 5'd7,  32'h77,   0, 5'd0, 5'd7,  32'h77,   0};
    vecs[5] = '{"rsvwin7",  1, 5'd7, 32'h88,       0, 5'd0,  32'h0,    1, 5'd7, 5'd7,  32'h88,   1};
    vecs[6] = '{"dual",     1, 5'd9, 32'h12,       1, 5'd10, 32'h34,   0, 5'd0, 5'd10, 32'h34,   0};
    vecs[7] = '{"rsvwin9",  0, 5'd0, 32'h0,        1, 5'd9,  32'hAB,   1, 5'd9, 5'd9,  32'hAB,   1};

    idle_inputs();
    read_addr1 = '0; read_addr2 = '0;
    rst = 1;
    @(negedge clk);

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      read_addr1 = AW'($urandom); read_addr2 = AW'($urandom);
      #1 check_all("reset");
    end

    // Init walk: ready must rise exactly after the DEPTH-th edge.
    rst = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      read_addr1 = AW'($urandom); read_addr2 = AW'($urandom);
      #1;
      chk("ready_rise", 32'(ready), 32'(k == DEPTH));
      chk("init_read", read1, 32'h0);
    end

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      WE = vecs[i].we; write_addr = vecs[i].wa; data = vecs[i].d;
      WE2 = vecs[i].we2; write_addr2 = vecs[i].wa2; data2 = vecs[i].d2;
      rsv_en = vecs[i].rsv; rsv_addr = vecs[i].ra;
      #1 check_all({vecs[i].name, "_pre"});
      tick();
      idle_inputs();
      read_addr1 = vecs[i].chk_a; read_addr2 = vecs[i].chk_a;
      #1;
      chk({vecs[i].name, "_rd1"},  read1, vecs[i].exp_d);
      chk({vecs[i].name, "_rd2"},  read2, vecs[i].exp_d);
      chk({vecs[i].name, "_bz1"},  32'(busy1), 32'(vecs[i].exp_b));
      chk({vecs[i].name, "_bz2"},  32'(busy2), 32'(vecs[i].exp_b));
    end

    // Randomized traffic with a narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      WE = 1'($urandom); WE2 = 1'($urandom); rsv_en = ($urandom_range(0, 3) == 0);
      write_addr  = AW'($urandom_range(0, 7));
      write_addr2 = AW'($urandom_range(0, 7));
      rsv_addr    = AW'($urandom_range(0, 7));
      data = $urandom; data2 = $urandom;
      read_addr1 = AW'($urandom_range(0, 7));
      read_addr2 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      #1 check_all("rand");
      tick();
    end
    idle_inputs();

    // Reset in RUN after writing register 4.
    WE = 1; write_addr = 5'd4; data = 32'd6;
    tick();
    idle_inputs();
    read_addr1 = 5'd4; read_addr2 = 5'd4;
    #1 chk("pre_rst_rd4", read1, 32'd6);
    rst = 1;
    tick();
    #1 chk("rst_ready_drop", 32'(ready), 32'h0);
    chk("rst_rd4", read1, 32'h0);
    rst = 0;
    for (int k = 0; k < DEPTH; k++) tick();
    #1 chk("reinit_ready", 32'(ready), 32'h1);
    chk("reinit_rd4", read1, 32'h0);
    chk("reinit_bz4", 32'(busy2), 32'h0);
    check_all("reinit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
